// File: rtl/m1m2_pkg.sv
// m1m2_pkg: shared types and defaults for the m1->m2 ready/execute link.
package m1m2_pkg;
    localparam int TAG_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;
    typedef logic [TAG_W_DEF-1:0] tag_t;
    typedef enum logic [1:0] {IDLE, ARM, HOLD, RELEASE} state_t;
endpackage

// File: rtl/m1_cmd_fifo.sv
// m1_cmd_fifo: synchronous tag FIFO with full/empty flags; DEPTH must be a power of 2.
module m1_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             push,
    input  logic [TAG_W-1:0] din,
    input  logic             pop,
    output logic [TAG_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q] = din;
        wr_d  = wr_en ? wr_q + PW'(1) : wr_q;
        rd_d  = rd_en ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/m1_ready_issuer.sv
// m1_ready_issuer: buffers tagged commands and issues them over the ready/execute link.
// Define M1_ISSUE_CNT_EN to implement the completion counter; otherwise issue_cnt is tied to 0.
module m1_ready_issuer
    import m1m2_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             isolateM1M2,
    input  logic             cmd_valid,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             cmd_ready,
    output logic             ready,
    input  logic             execute,
    output logic             done_valid,
    output logic [TAG_W-1:0] done_tag,
    output logic             timeout_err,
    output logic [CNT_W-1:0] issue_cnt
);
    localparam int TW = $clog2(TIMEOUT);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d, done_tag_q, done_tag_d, head;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ready_q, ready_d, done_valid_q, done_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             fifo_full, fifo_empty, pop, exe, can_issue;

    assign cmd_ready   = ~fifo_full;
    assign exe         = execute & ~isolateM1M2;
    assign can_issue   = ~fifo_empty & ~isolateM1M2;
    assign ready       = ready_q;
    assign done_valid  = done_valid_q;
    assign done_tag    = done_tag_q;
    assign timeout_err = timeout_err_q;

    m1_cmd_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
        .ck    (ck),
        .arst  (arst),
        .push  (cmd_valid & ~fifo_full),
        .din   (cmd_tag),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        timer_d       = timer_q;
        ready_d       = 1'b0;
        done_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
        done_tag_d    = done_tag_q;
        pop           = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                // RELEASE waits for the echo to drop so one ready pulse maps to one execute pulse
                if (state_q == IDLE || !exe) begin
                    state_d = IDLE;
                    if (can_issue) begin
                        pop     = 1'b1;
                        tag_d   = head;
                        ready_d = 1'b1;
                        timer_d = '0;
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                if (isolateM1M2) begin
                    state_d = HOLD;
                end else if (exe) begin
                    done_valid_d = 1'b1;
                    done_tag_d   = tag_q;
                    state_d      = RELEASE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    done_tag_d    = tag_q;
                    state_d       = RELEASE;
                end else begin
                    ready_d = 1'b1;
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (!isolateM1M2) begin
                    ready_d = 1'b1;
                    timer_d = '0;
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state_q       <= IDLE;
            tag_q         <= '0;
            timer_q       <= '0;
            ready_q       <= 1'b0;
            done_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            done_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            timer_q       <= timer_d;
            ready_q       <= ready_d;
            done_valid_q  <= done_valid_d;
            timeout_err_q <= timeout_err_d;
            done_tag_q    <= done_tag_d;
        end
    end

`ifdef M1_ISSUE_CNT_EN
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + CNT_W'(done_valid_d);
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) issue_cnt_q <= '0;
        else      issue_cnt_q <= issue_cnt_d;
    end

    assign issue_cnt = issue_cnt_q;
`else
    assign issue_cnt = '0;
`endif
endmodule

// File: tb/tb_m1_ready_issuer.sv
// tb_m1_ready_issuer: directed scenario bench for m1_ready_issuer with a registered echo model.
module tb_m1_ready_issuer;
    logic       ck = 1'b0, arst = 1'b1, iso = 1'b0, cmd_valid = 1'b0, stuck = 1'b0;
    logic [3:0] cmd_tag = '0;
    logic       cmd_ready, ready, execute, done_valid, timeout_err;
    logic [3:0] done_tag;
    logic [1:0] issue_cnt;
    logic [1:0] exp_cnt = '0;
    int         tests = 0, fails = 0;

    m1_ready_issuer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(16), .CNT_W(2)) dut (
        .ck          (ck),
        .arst        (arst),
        .isolateM1M2 (iso),
        .cmd_valid   (cmd_valid),
        .cmd_tag     (cmd_tag),
        .cmd_ready   (cmd_ready),
        .ready       (ready),
        .execute     (execute),
        .done_valid  (done_valid),
        .done_tag    (done_tag),
        .timeout_err (timeout_err),
        .issue_cnt   (issue_cnt)
    );

    always #5 ck = ~ck;

    // downstream stage: echoes ready one cycle later unless forced stuck
    always_ff @(posedge ck or posedge arst) begin
        if (arst) execute <= 1'b0;
        else      execute <= ready & ~stuck;
    end

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic bump;
`ifdef M1_ISSUE_CNT_EN
        exp_cnt = exp_cnt + 2'd1;
`endif
    endtask

    task automatic test_reset;
        arst = 1'b1; cmd_valid = 1'b1; cmd_tag = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++;
            if ({ready, cmd_ready, done_valid, timeout_err, issue_cnt} !== 6'b010000) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d got rdy=%b crdy=%b dv=%b te=%b cnt=%0d exp 0 1 0 0 0",
                         i, ready, cmd_ready, done_valid, timeout_err, issue_cnt);
            end
        end
        cmd_valid = 1'b0; arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++;
            if (ready !== 1'b0 || cmd_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_nopush cyc=%0d got rdy=%b crdy=%b exp 0 1", i, ready, cmd_ready);
            end
        end
    endtask

    task automatic test_mid_reset;
        cmd_valid = 1'b1; cmd_tag = 4'hA;
        tick;
        cmd_valid = 1'b0;
        tick;
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL midrst_issue got %b exp 1", ready); end
        #1 arst = 1'b1;
        #1;
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL midrst_async got %b exp 0", ready); end
        arst = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 6; i++) begin
            tick;
            tests++;
            if (ready !== 1'b0 || done_valid !== 1'b0 || timeout_err !== 1'b0 || issue_cnt !== 2'd0) begin
                fails++;
                $display("FAIL midrst_discard cyc=%0d got rdy=%b dv=%b te=%b cnt=%0d exp 0 0 0 0",
                         i, ready, done_valid, timeout_err, issue_cnt);
            end
        end
    endtask

    task automatic test_single;
        cmd_valid = 1'b1; cmd_tag = 4'h3;
        tick;
        cmd_valid = 1'b0;
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL single_t0 ready got %b exp 0", ready); end
        tick;
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL single_t1 ready got %b exp 1", ready); end
        tick;
        tests++;
        if (ready !== 1'b1 || done_valid !== 1'b0) begin
            fails++; $display("FAIL single_t2 got rdy=%b dv=%b exp 1 0", ready, done_valid);
        end
        tick;
        bump;
        tests++;
        if (ready !== 1'b0 || done_valid !== 1'b1 || done_tag !== 4'h3 || issue_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL single_t3 got rdy=%b dv=%b tag=%h cnt=%0d exp 0 1 3 %0d",
                     ready, done_valid, done_tag, issue_cnt, exp_cnt);
        end
        tick;
        tests++;
        if (done_valid !== 1'b0 || ready !== 1'b0) begin
            fails++; $display("FAIL single_t4 got rdy=%b dv=%b exp 0 0", ready, done_valid);
        end
        tick;
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL single_t5 ready got %b exp 0", ready); end
    endtask

    task automatic test_back_to_back;
        logic exp_rdy, exp_dv;
        logic [3:0] exp_tag;
        iso = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cmd_valid = 1'b1; cmd_tag = 4'(i);
            tests++;
            if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_fill%0d cmd_ready got %b exp 1", i, cmd_ready); end
            tick;
        end
        cmd_tag = 4'h5;
        tests++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_full cmd_ready got %b exp 0", cmd_ready); end
        tick;
        tests++;
        if (cmd_ready !== 1'b0 || ready !== 1'b0) begin
            fails++; $display("FAIL b2b_held got crdy=%b rdy=%b exp 0 0", cmd_ready, ready);
        end
        iso = 1'b0;
        tick;
        tests++;
        if (ready !== 1'b1 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_firstpop got rdy=%b crdy=%b exp 1 1", ready, cmd_ready);
        end
        for (int k = 1; k < 20; k++) begin
            tick;
            if (k == 1) cmd_valid = 1'b0;
            exp_rdy = (k % 4 == 0 || k % 4 == 1) && k < 18;
            exp_dv  = (k % 4 == 2) && k <= 18;
            exp_tag = 4'((k - 2) / 4 + 1);
            if (exp_dv) bump;
            tests++;
            if (ready !== exp_rdy || done_valid !== exp_dv || (exp_dv && (done_tag !== exp_tag || issue_cnt !== exp_cnt))) begin
                fails++;
                $display("FAIL b2b_seq k=%0d got rdy=%b dv=%b tag=%h cnt=%0d exp %b %b %h %0d",
                         k, ready, done_valid, done_tag, issue_cnt, exp_rdy, exp_dv, exp_tag, exp_cnt);
            end
        end
    endtask

    task automatic test_timeout;
        stuck = 1'b1;
        cmd_valid = 1'b1; cmd_tag = 4'h7;
        tick;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            tests++;
            if (ready !== 1'b1 || timeout_err !== 1'b0 || done_valid !== 1'b0) begin
                fails++;
                $display("FAIL tmo_arm k=%0d got rdy=%b te=%b dv=%b exp 1 0 0", k, ready, timeout_err, done_valid);
            end
        end
        tick;
        tests++;
        if (ready !== 1'b0 || timeout_err !== 1'b1 || done_tag !== 4'h7 || done_valid !== 1'b0 || issue_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL tmo_abort got rdy=%b te=%b tag=%h dv=%b cnt=%0d exp 0 1 7 0 %0d",
                     ready, timeout_err, done_tag, done_valid, issue_cnt, exp_cnt);
        end
        tick;
        tests++;
        if (timeout_err !== 1'b0 || ready !== 1'b0) begin
            fails++; $display("FAIL tmo_pulse got te=%b rdy=%b exp 0 0", timeout_err, ready);
        end
        stuck = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_isolation;
        cmd_valid = 1'b1; cmd_tag = 4'h9;
        tick;
        cmd_valid = 1'b0;
        tick;
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL iso_issue ready got %b exp 1", ready); end
        iso = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            tick;
            tests++;
            if (ready !== 1'b0 || done_valid !== 1'b0 || timeout_err !== 1'b0) begin
                fails++;
                $display("FAIL iso_hold k=%0d got rdy=%b dv=%b te=%b exp 0 0 0", k, ready, done_valid, timeout_err);
            end
        end
        iso = 1'b0;
        tick;
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL iso_reissue ready got %b exp 1", ready); end
        tick;
        tests++;
        if (ready !== 1'b1 || done_valid !== 1'b0) begin
            fails++; $display("FAIL iso_rearm got rdy=%b dv=%b exp 1 0", ready, done_valid);
        end
        tick;
        bump;
        tests++;
        if (ready !== 1'b0 || done_valid !== 1'b1 || done_tag !== 4'h9 || issue_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL iso_done got rdy=%b dv=%b tag=%h cnt=%0d exp 0 1 9 %0d",
                     ready, done_valid, done_tag, issue_cnt, exp_cnt);
        end
        tick;
        tick;
    endtask

    task automatic test_wrap;
        logic [1:0] seq;
        #1 arst = 1'b1;
        #1 arst = 1'b0;
        exp_cnt = '0;
        for (int i = 1; i <= 5; i++) begin
            cmd_valid = 1'b1; cmd_tag = 4'(i + 10);
            tick;
            cmd_valid = 1'b0;
            tick;
            tick;
            tick;
            bump;
`ifdef M1_ISSUE_CNT_EN
            seq = 2'(i);
`else
            seq = 2'd0;
`endif
            tests++;
            if (done_valid !== 1'b1 || done_tag !== 4'(i + 10) || issue_cnt !== exp_cnt || issue_cnt !== seq) begin
                fails++;
                $display("FAIL wrap_cnt i=%0d got dv=%b tag=%h cnt=%0d exp 1 %h %0d",
                         i, done_valid, done_tag, issue_cnt, 4'(i + 10), seq);
            end
            tick;
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_mid_reset;
        test_single;
        test_back_to_back;
        test_timeout;
        test_isolation;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
